// File: rtl/stack_pkg.sv
// Shared constants for the stack driver: default geometry, command opcodes and FSM states.
package stack_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 256;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RSP   = 2'd3
  } state_e;

endpackage

// File: rtl/stack_level_ctr.sv
// Saturating up/down occupancy counter (0..DEPTH) shadowing the stack fill level.
module stack_level_ctr #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [LW-1:0] level_o,
  output logic          is_zero_o,
  output logic          is_max_o
);

  localparam logic [LW-1:0] MaxLevel = LW'(DEPTH);

  logic [LW-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (inc_i && !dec_i && level_q != MaxLevel) begin
      level_d = level_q + LW'(1);
    end else if (dec_i && !inc_i && level_q != '0) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o   = level_q;
  assign is_zero_o = (level_q == '0);
  assign is_max_o  = (level_q == MaxLevel);

endmodule

// File: rtl/stack_driver.sv
// Initiator for a push/pop stack: one strobe and one response per accepted command,
// with a shadow level counter cross-checked against the stack flags.
module stack_driver
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [LW-1:0]    level,
  output logic             sync_err
);

  state_e           state_q;
  logic             op_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             sync_err_q;

  logic push_ok, pop_ok;
  logic lvl_zero, lvl_max;
  logic sync_mismatch;

  // Flags are sampled in ISSUE itself, so the strobes decode combinationally from them.
  assign push_ok = (state_q == S_ISSUE) && (op_q == OP_PUSH) && !stk_full;
  assign pop_ok  = (state_q == S_ISSUE) && (op_q == OP_POP) && !stk_empty;

  assign sync_mismatch = (lvl_zero != stk_empty) || (lvl_max != stk_full);

  stack_level_ctr #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_level_ctr (
    .clk_i     (clk),
    .rst_ni    (rst),
    .inc_i     (push_ok),
    .dec_i     (pop_ok),
    .level_o   (level),
    .is_zero_o (lvl_zero),
    .is_max_o  (lvl_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PUSH;
      din_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && sync_mismatch) begin
        sync_err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            // Only pushes load the data register so stk_data_in stays put otherwise.
            if (cmd_op == OP_PUSH) begin
              din_q <= cmd_data;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rsp_data_q <= '0;
          if (push_ok) begin
            rsp_err_q <= 1'b0;
            state_q   <= S_RSP;
          end else if (pop_ok) begin
            rsp_err_q <= 1'b0;
            state_q   <= S_WAIT;
          end else begin
            rsp_err_q <= 1'b1;
            state_q   <= S_RSP;
          end
        end
        S_WAIT: begin
          rsp_data_q <= stk_data_out;
          state_q    <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RSP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign stk_push    = push_ok;
  assign stk_pop     = pop_ok;
  assign stk_data_in = din_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_stack_driver.sv
// Directed bench for stack_driver with a behavioural stack model behind the stack port.
module tb_stack_driver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int LW    = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out;
  logic             stk_full, stk_empty;
  logic [LW-1:0]    level;
  logic             sync_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .level        (level),
    .sync_err     (sync_err)
  );

  // Behavioural stack: registered read data, reset from the same source inverted.
  logic [WIDTH-1:0] mem [DEPTH];
  int  cnt;
  bit  force_nonempty = 1'b0;
  int  push_cnt = 0, pop_cnt = 0, both_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 0;
      stk_data_out <= '0;
    end else begin
      if (stk_push && cnt < DEPTH) begin
        mem[cnt] <= stk_data_in;
        cnt      <= cnt + 1;
      end else if (stk_pop && cnt > 0) begin
        stk_data_out <= mem[cnt-1];
        cnt          <= cnt - 1;
      end
    end
  end

  assign stk_full  = (cnt == DEPTH);
  assign stk_empty = (cnt == 0) && !force_nonempty;

  always @(posedge clk) begin
    if (rst) begin
      if (stk_push) push_cnt++;
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One command; hold = cycles to keep rsp_ready low once the response appears.
  task automatic do_cmd(input bit op, input logic [WIDTH-1:0] d, input int hold,
                        output logic [WIDTH-1:0] rd, output bit er, output int lat,
                        output bit stable);
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc       = 1;
    stable    = 1'b1;
    while (!rsp_valid && cyc < 20) begin
      if (cmd_ready) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    rd  = rsp_data;
    er  = rsp_err;
    if (!rsp_valid) check("rsp_valid timeout", 32'd0, 32'd1);
    for (int k = 0; k < hold; k++) begin
      if (!rsp_valid || rsp_data !== rd || rsp_err !== er || cmd_ready) stable = 1'b0;
      @(negedge clk);
    end
    if (!rsp_valid || rsp_data !== rd || rsp_err !== er || cmd_ready) stable = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit               op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_data;
    bit               exp_err;
    int               exp_lat;
    int               exp_level;
    int               exp_push;
    int               exp_pop;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [WIDTH-1:0] rd;
    bit er, st;
    int lat, p0, q0, errs;

    vecs[0] = '{1'b1, 8'h00, 8'h00, 1'b1, 2, 0, 0, 0};
    vecs[1] = '{1'b0, 8'd10, 8'h00, 1'b0, 2, 1, 1, 0};
    vecs[2] = '{1'b0, 8'd20, 8'h00, 1'b0, 2, 2, 1, 0};
    vecs[3] = '{1'b0, 8'd5,  8'h00, 1'b0, 2, 3, 1, 0};
    vecs[4] = '{1'b0, 8'd25, 8'h00, 1'b0, 2, 4, 1, 0};
    vecs[5] = '{1'b1, 8'hEE, 8'd25, 1'b0, 3, 3, 0, 1};
    vecs[6] = '{1'b1, 8'hEE, 8'd5,  1'b0, 3, 2, 0, 1};
    vecs[7] = '{1'b1, 8'hEE, 8'd20, 1'b0, 3, 1, 0, 1};
    vecs[8] = '{1'b1, 8'hEE, 8'd10, 1'b0, 3, 0, 0, 1};
    vecs[9] = '{1'b1, 8'h33, 8'h00, 1'b1, 2, 0, 0, 0};

    // Reset state
    #12;
    check("reset ctl {cmd_ready,rsp_valid,rsp_err,push,pop,sync_err}",
          {26'd0, cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, sync_err}, 32'b100000);
    check("reset rsp_data", rsp_data, 0);
    check("reset level", level, 0);
    check("reset stk_data_in", stk_data_in, 0);
    @(negedge clk);
    rst = 1'b1;

    // Pushes/pops in LIFO order plus error pops on an empty stack
    for (int i = 0; i < 10; i++) begin
      p0 = push_cnt;
      q0 = pop_cnt;
      do_cmd(vecs[i].op, vecs[i].data, 0, rd, er, lat, st);
      check($sformatf("v%0d rsp_data", i), rd, vecs[i].exp_data);
      check($sformatf("v%0d rsp_err", i), er, vecs[i].exp_err);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d level", i), level, vecs[i].exp_level);
      check($sformatf("v%0d push strobes", i), push_cnt - p0, vecs[i].exp_push);
      check($sformatf("v%0d pop strobes", i), pop_cnt - q0, vecs[i].exp_pop);
      check($sformatf("v%0d cmd_ready busy", i), st, 1);
    end

    // Fill to DEPTH, then push on full
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(1'b0, 8'(i), 0, rd, er, lat, st);
      if (er) errs++;
    end
    check("fill errors", errs, 0);
    check("fill level", level, DEPTH);
    p0 = push_cnt;
    do_cmd(1'b0, 8'hAA, 0, rd, er, lat, st);
    check("push full err", er, 1);
    check("push full data", rd, 0);
    check("push full latency", lat, 2);
    check("push full strobes", push_cnt - p0, 0);
    check("push full level", level, DEPTH);
    do_cmd(1'b1, 8'h00, 0, rd, er, lat, st);
    check("pop after full data", rd, 8'd255);
    check("pop after full err", er, 0);
    check("pop after full level", level, DEPTH - 1);

    // Response held by back-pressure
    do_cmd(1'b0, 8'h5A, 0, rd, er, lat, st);
    do_cmd(1'b1, 8'h00, 3, rd, er, lat, st);
    check("hold rsp_data", rd, 8'h5A);
    check("hold rsp_err", er, 0);
    check("hold stable", st, 1);
    check("hold rsp_valid drop", rsp_valid, 0);
    check("strobes never overlap", both_cnt, 0);

    // Reset during WAIT of a pending POP
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset ctl {cmd_ready,rsp_valid,rsp_err,push,pop,sync_err}",
          {26'd0, cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, sync_err}, 32'b100000);
    check("midreset level", level, 0);
    check("midreset rsp_data", rsp_data, 0);
    check("midreset stk_data_in", stk_data_in, 0);
    @(negedge clk);
    rst = 1'b1;
    do_cmd(1'b1, 8'h00, 0, rd, er, lat, st);
    check("pop after reset err", er, 1);
    check("pop after reset data", rd, 0);

    // Flag/level disagreement
    check("sync_err clear", sync_err, 0);
    @(negedge clk);
    force_nonempty = 1'b1;
    @(negedge clk);
    check("sync_err set", sync_err, 1);
    force_nonempty = 1'b0;
    repeat (3) @(negedge clk);
    check("sync_err sticky", sync_err, 1);
    rst = 1'b0;
    #1;
    check("sync_err reset", sync_err, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
